// File: rtl/gf_inv_seq.sv
// Sequential GF(2^8) inverse: a^254 by seven square-and-multiply steps, one
// operand in flight, fixed 7-cycle compute latency, result held until taken.

module gf_mul #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] shifted;

  // Walk the bits of b, keeping a*x^i reduced so nothing exceeds 8 bits.
  always_comb begin
    p_o     = 8'h00;
    shifted = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) p_o = p_o ^ shifted;
      shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? POLY : 8'h00);
    end
  end

endmodule

module gf_inv_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] sq_q, sq_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic [7:0] sq_sq;
  logic [7:0] acc_s;

  gf_mul #(.POLY(POLY)) u_square (.a_i(sq_q), .b_i(sq_q),  .p_o(sq_sq));
  gf_mul #(.POLY(POLY)) u_accum  (.a_i(acc_q), .b_i(sq_sq), .p_o(acc_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sq_q    <= 8'h00;
      acc_q   <= 8'h01;
      cnt_q   <= 3'd0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Step k squares to a^(2^k) and folds it into acc; after 7 steps
  // acc = a^(2+4+...+128) = a^254.
  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sq_d    = in_data;
          acc_d   = 8'h01;
          cnt_d   = 3'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sq_d  = sq_sq;
        acc_d = acc_s;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          out_d   = acc_s;
          cnt_d   = 3'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_gf_inv_seq.sv
// Directed and sweep checks for gf_inv_seq: latency, hold under backpressure,
// async reset abort, throughput and the full inverse table.

module tb_gf_inv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  gf_inv_seq #(.POLY(8'h1B)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = t[7] ? (({t[6:0], 1'b0}) ^ 8'h1B) : {t[6:0], 1'b0};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with the block idle; returns after the accept edge.
  task automatic accept(input string tag, input logic [7:0] a);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = a;
    step();
    in_valid = 1'b0;
    in_data  = ~a;
  endtask

  task automatic wait_result(input string tag, input logic [7:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 7);
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
  endtask

  logic [7:0] ops  [4] = '{8'h00, 8'h01, 8'h02, 8'hCA};
  logic [7:0] exps [4] = '{8'h00, 8'h01, 8'h8D, 8'h53};
  logic [7:0] b2b_ops  [4] = '{8'h53, 8'hCA, 8'h02, 8'h8D};
  logic [7:0] b2b_exps [4] = '{8'hCA, 8'h53, 8'h8D, 8'h02};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 8'h00);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_reset_in_ready", in_ready, 1'b1);

    accept("a53", 8'h53);
    wait_result("a53", 8'hCA);
    consume("a53");

    for (int i = 0; i < 4; i++) begin
      accept($sformatf("dir%0d", i), ops[i]);
      wait_result($sformatf("dir%0d", i), exps[i]);
      consume($sformatf("dir%0d", i));
    end

    // Hold under backpressure while a new operand is offered.
    accept("hold", 8'h02);
    wait_result("hold", 8'h8D);
    in_valid = 1'b1;
    in_data  = 8'h53;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_data%0d", i), out_data, 8'h8D);
      chk($sformatf("hold_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("hold_in_ready%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_released_in_ready", in_ready, 1'b1);
    accept("hold_next", 8'h53);
    wait_result("hold_next", 8'hCA);
    consume("hold_next");

    // Async reset three cycles into BUSY; out_data still holds CA beforehand.
    accept("abort", 8'h02);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, 8'h00);
    chk("abort_in_ready", in_ready, 1'b1);
    #1;
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", seen, 1'b0);
    end
    accept("after_abort", 8'h53);
    wait_result("after_abort", 8'hCA);
    consume("after_abort");

    // Back-to-back traffic: one result every 9 cycles.
    begin
      int nxt;
      int got;
      int last_cyc;
      nxt = 0;
      got = 0;
      last_cyc = 0;
      out_ready = 1'b1;
      for (int t = 0; t < 80 && got < 4; t++) begin
        if (out_valid) begin
          chk($sformatf("b2b_data%0d", got), out_data, b2b_exps[got]);
          if (got > 0) chk($sformatf("b2b_gap%0d", got), cyc - last_cyc, 9);
          last_cyc = cyc;
          got++;
        end
        if (in_ready && nxt < 4) begin
          in_valid = 1'b1;
          in_data  = b2b_ops[nxt];
          nxt++;
        end else if (in_ready) begin
          in_valid = 1'b0;
        end
        step();
      end
      chk("b2b_count", got, 4);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
    end

    // Full sweep with random backpressure; results checked via a*inv = 1.
    begin
      int issue;
      int expect_a;
      issue = 1;
      expect_a = 1;
      for (int t = 0; t < 10000 && expect_a <= 255; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          chk($sformatf("sweep_inv_%0h", expect_a),
              ref_mul(out_data, 8'(expect_a)), 8'h01);
          expect_a++;
        end
        if (in_ready) begin
          if (issue <= 255) begin
            in_valid = 1'b1;
            in_data  = 8'(issue);
            issue++;
          end else begin
            in_valid = 1'b0;
          end
        end
        step();
      end
      chk("sweep_count", expect_a - 1, 255);
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
